alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Initiator side of the ALU control interface. Accepts R-type ALU commands (funct plus two 32-bit operands) over a valid/ready handshake.
- Decodes funct to the 4-bit ALU control code and drives the external ALU's a/b/ALUctl inputs. After a fixed settle cycle it captures the ALU output and zero flag, then returns them over a valid/ready response channel.
- Sits between the instruction-issue logic and the ALU datapath. Counts completed and rejected operations.

Parameters:
- DATA_W, 32, operand/result width.
- SETTLE_CYC, 1, cycles the ALU inputs are held before capture (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  issuer can accept a command.
- cmd_funct  input  6  R-type funct field.
- cmd_a  input  DATA_W  operand A.
- cmd_b  input  DATA_W  operand B.
- alu_a  output  DATA_W  driven to ALU a.
- alu_b  output  DATA_W  driven to ALU b.
- alu_ctl  output  4  driven to ALU ALUctl.
- alu_out  input  DATA_W  ALU result.
- alu_zero  input  2  ALU zero flag; any nonzero bit means the result is zero.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DATA_W  captured result.
- rsp_zero  output  1  captured zero (|alu_zero).
- rsp_err  output  1  illegal funct; data forced to 0.
- op_count  output  16  completed legal ops, wraps at 0xFFFF->0.
- err_count  output  8  illegal-funct ops, saturates at 0xFF.

Behaviour:
- Reset (async, rst_n=0) sets every output to 0: state IDLE, cmd_ready=0 during reset, alu_a/alu_b=0, alu_ctl=4'b0000, rsp_*=0, counters=0. Deasserting reset mid-operation drops the in-flight op and emits no response.
- Funct decode:
  - 100100 AND -> 0000
  - 100101 OR -> 0001
  - 100000 add -> 0010
  - 100010 sub -> 0110
  - 101010 slt -> 0111
  - 100111 nor -> 1100
  - any other funct is illegal.
- States and transitions:
  - IDLE: cmd_ready=1. Handshake (cmd_valid&cmd_ready) registers cmd_a/cmd_b onto alu_a/alu_b and the decoded code onto alu_ctl. Legal funct goes to SETTLE with the settle counter loaded to SETTLE_CYC-1. Illegal funct goes to RESP with rsp_err=1, rsp_data=0, rsp_zero=0, alu_* unchanged.
  - SETTLE: cmd_ready=0; alu_a/alu_b/alu_ctl held stable. When the counter reaches 0, capture alu_out into rsp_data and |alu_zero into rsp_zero, set rsp_err=0, go to RESP.
  - RESP: rsp_valid=1. rsp_data/rsp_zero/rsp_err are stable until the handshake (rsp_valid&rsp_ready), which returns to IDLE and increments op_count or err_count.
- Latency: with SETTLE_CYC=1 and rsp_ready held high, rsp_valid rises 2 cycles after the cmd handshake edge and cmd_ready reasserts the cycle after the response handshake. One op in flight; no pipelining.
- rsp_valid is never withdrawn without a handshake.
- cmd inputs are ignored outside IDLE.
- err_count holds at 0xFF; op_count wraps to 0.
- alu_* keep their last values in IDLE; no glitch to 0 between ops.

Decomposition:
- Package alu_pkg holds the localparams: the six funct codes, the six ALUctl codes (CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR), and the state encoding (IDLE, SETTLE, RESP).
- One sub-module, alu_funct_decode: combinational, funct[5:0] -> ctl[3:0] plus illegal flag. Shared later with the full control unit.

Test Plan:
- Legal op sweep, ALU model attached: a=0x55555555, b=0xAAAAAAAA through AND/OR/add/sub/slt -> rsp_data 0x00000000 (zero=1), 0xFFFFFFFF, 0xFFFFFFFF, 0xAAAAAAAB, 0x00000000 (slt signed: a>b), rsp_err=0, op_count=5.
- Swapped slt: a=0xAAAAAAAA, b=0x55555555, funct=101010 -> alu_ctl=0111, rsp_data=0x00000001, rsp_zero=0.
- Illegal funct 000000 -> rsp_err=1, rsp_data=0, err_count=1, op_count unchanged, alu_ctl unchanged from the previous op.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with stable data and cmd_ready stays 0. Further cmd_valid pulses are ignored. Response and count increment occur only at rsp_ready=1.
- Reset mid-op: assert rst_n=0 during SETTLE -> all outputs 0 immediately (async). After release, cmd_ready=1 next cycle and no stale rsp_valid.
- Counter limits: 256 illegal ops -> err_count holds 0xFF. Preload by forcing op_count to 0xFFFF, then one legal op -> op_count=0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control path.
// Holds the R-type funct codes, the 4-bit ALU control codes the external ALU
// understands, and the state encoding of the op issuer.
package alu_pkg;

  // R-type funct field values for the supported ALU operations
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // ALUctl codes presented to the ALU datapath
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  // Issuer states: waiting for a command, holding ALU inputs, offering a response
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder.
// Ports:
//   funct_i   - 6-bit funct field
//   ctl_o     - 4-bit ALU control code (0 when the funct is illegal)
//   illegal_o - high when funct is not one of the six supported operations
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] ctl_o,
  output logic       illegal_o
);

  // Map each supported funct to its ALUctl; everything else is flagged illegal
  always_comb begin
    ctl_o     = 4'b0000;
    illegal_o = 1'b0;
    case (funct_i)
      FUNCT_AND: ctl_o = CTL_AND;
      FUNCT_OR:  ctl_o = CTL_OR;
      FUNCT_ADD: ctl_o = CTL_ADD;
      FUNCT_SUB: ctl_o = CTL_SUB;
      FUNCT_SLT: ctl_o = CTL_SLT;
      FUNCT_NOR: ctl_o = CTL_NOR;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// ALU op issuer: initiator side of the ALU control interface.
// Accepts one R-type command at a time, drives the external ALU, waits a fixed
// number of settle cycles, captures the result and offers it as a response.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   - command handshake
//   cmd_funct_i, cmd_a_i/_b_i   - funct field and operands
//   alu_a_o, alu_b_o, alu_ctl_o - registered ALU inputs
//   alu_out_i, alu_zero_i       - ALU result and zero flag (any set bit = zero)
//   rsp_valid_o / rsp_ready_i   - response handshake
//   rsp_data_o, rsp_zero_o      - captured result and zero flag
//   rsp_err_o                   - command had an illegal funct
//   op_count_o                  - completed legal ops (wrapping)
//   err_count_o                 - illegal ops (saturating)
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [5:0]        cmd_funct_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [3:0]        alu_ctl_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [1:0]        alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o,
  output logic [15:0]       op_count_o,
  output logic [7:0]        err_count_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        settleCnt_q, settleCnt_d;
  logic [DATA_W-1:0] aluA_q, aluA_d;
  logic [DATA_W-1:0] aluB_q, aluB_d;
  logic [3:0]        aluCtl_q, aluCtl_d;
  logic [DATA_W-1:0] rspData_q, rspData_d;
  logic              rspZero_q, rspZero_d;
  logic              rspErr_q, rspErr_d;
  logic [15:0]       opCount_q, opCount_d;
  logic [7:0]        errCount_q, errCount_d;
  logic              outOfReset_q;

  logic [3:0]        decCtl;
  logic              decIllegal;
  logic              cmdFire;

  alu_funct_decode u_decode (
    .funct_i   (cmd_funct_i),
    .ctl_o     (decCtl),
    .illegal_o (decIllegal)
  );

  // cmd_ready must read 0 while reset is held, so ready is additionally
  // gated by a flag that only sets on the first clock after reset release
  assign cmd_ready_o = (state_q == IDLE) && outOfReset_q;
  assign cmdFire     = cmd_valid_i && cmd_ready_o;

  // Next-state and datapath updates; every register holds by default so the
  // ALU inputs stay put between ops
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    aluCtl_d    = aluCtl_q;
    rspData_d   = rspData_q;
    rspZero_d   = rspZero_q;
    rspErr_d    = rspErr_q;
    opCount_d   = opCount_q;
    errCount_d  = errCount_q;
    case (state_q)
      IDLE: begin
        if (cmdFire) begin
          if (decIllegal) begin
            // Illegal funct never reaches the ALU; answer straight away
            rspErr_d  = 1'b1;
            rspData_d = '0;
            rspZero_d = 1'b0;
            state_d   = RESP;
          end else begin
            aluA_d      = cmd_a_i;
            aluB_d      = cmd_b_i;
            aluCtl_d    = decCtl;
            settleCnt_d = SETTLE_LOAD;
            state_d     = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (settleCnt_q == 4'd0) begin
          rspData_d = alu_out_i;
          rspZero_d = |alu_zero_i;
          rspErr_d  = 1'b0;
          state_d   = RESP;
        end else begin
          settleCnt_d = settleCnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          if (rspErr_q) begin
            if (errCount_q != 8'hFF) begin
              errCount_d = errCount_q + 8'd1;
            end
          end else begin
            opCount_d = opCount_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and drops any op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settleCnt_q  <= 4'd0;
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluCtl_q     <= 4'b0000;
      rspData_q    <= '0;
      rspZero_q    <= 1'b0;
      rspErr_q     <= 1'b0;
      opCount_q    <= 16'd0;
      errCount_q   <= 8'd0;
      outOfReset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settleCnt_q  <= settleCnt_d;
      aluA_q       <= aluA_d;
      aluB_q       <= aluB_d;
      aluCtl_q     <= aluCtl_d;
      rspData_q    <= rspData_d;
      rspZero_q    <= rspZero_d;
      rspErr_q     <= rspErr_d;
      opCount_q    <= opCount_d;
      errCount_q   <= errCount_d;
      outOfReset_q <= 1'b1;
    end
  end

  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign alu_ctl_o   = aluCtl_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rspData_q;
  assign rsp_zero_o  = rspZero_q;
  assign rsp_err_o   = rspErr_q;
  assign op_count_o  = opCount_q;
  assign err_count_o = errCount_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: a behavioural ALU answers the issuer, expected
// responses are queued at issue time and a monitor compares them on handshake.
module tb_alu_op_issuer;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmdValid;
  logic        cmdReady;
  logic [5:0]  cmdFunct;
  logic [31:0] cmdA, cmdB;
  logic [31:0] aluA, aluB, aluOut;
  logic [3:0]  aluCtl;
  logic [1:0]  aluZero;
  logic        rspValid, rspReady, rspZero, rspErr;
  logic [31:0] rspData;
  logic [15:0] opCount;
  logic [7:0]  errCount;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  logic pendingRsp = 1'b0;

  alu_op_issuer #(.DATA_W(32), .SETTLE_CYC(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_funct_i (cmdFunct),
    .cmd_a_i     (cmdA),
    .cmd_b_i     (cmdB),
    .alu_a_o     (aluA),
    .alu_b_o     (aluB),
    .alu_ctl_o   (aluCtl),
    .alu_out_i   (aluOut),
    .alu_zero_i  (aluZero),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_data_o  (rspData),
    .rsp_zero_o  (rspZero),
    .rsp_err_o   (rspErr),
    .op_count_o  (opCount),
    .err_count_o (errCount)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; the zero flag is reported on the upper bit only
  always_comb begin
    aluOut = 32'h0;
    case (aluCtl)
      CTL_AND: aluOut = aluA & aluB;
      CTL_OR:  aluOut = aluA | aluB;
      CTL_ADD: aluOut = aluA + aluB;
      CTL_SUB: aluOut = aluA - aluB;
      CTL_SLT: aluOut = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
      CTL_NOR: aluOut = ~(aluA | aluB);
      default: aluOut = 32'h0;
    endcase
    aluZero = (aluOut == 32'h0) ? 2'b10 : 2'b00;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted response against the oldest expectation,
  // and make sure a stalled response is never withdrawn
  always @(negedge clk) begin
    if (pendingRsp) checkOutput("rsp_held", {31'd0, rspValid}, 32'd1);
    if (rst_n && rspValid && rspReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got data 0x%08h with no expectation", rspData);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_data", rspData, e.data);
        checkOutput("rsp_zero", {31'd0, rspZero}, {31'd0, e.zero});
        checkOutput("rsp_err", {31'd0, rspErr}, {31'd0, e.err});
      end
    end
    pendingRsp = rst_n && rspValid && !rspReady;
  end

  // Queue the expected response, then hold the command until it is accepted
  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expData, input logic expZero, input logic expErr);
    exp_t e;
    bit accepted;
    e.data = expData;
    e.zero = expZero;
    e.err  = expErr;
    expQ.push_back(e);
    cmdFunct = f;
    cmdA     = a;
    cmdB     = b;
    cmdValid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (cmdReady) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept: got no cmd_ready within 50 cycles, required 1");
      void'(expQ.pop_back());
    end else begin
      @(posedge clk);
      #1;
    end
    cmdValid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #2;
      if (expQ.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: got %0d responses pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    rst_n    = 1'b0;
    cmdValid = 1'b0;
    cmdFunct = 6'd0;
    cmdA     = 32'd0;
    cmdB     = 32'd0;
    rspReady = 1'b1;

    // Reset state
    #3;
    checkOutput("reset_cmd_ready", {31'd0, cmdReady}, 32'd0);
    checkOutput("reset_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("reset_alu_ctl", {28'd0, aluCtl}, 32'd0);
    checkOutput("reset_alu_a", aluA, 32'd0);
    checkOutput("reset_op_count", {16'd0, opCount}, 32'd0);
    checkOutput("reset_err_count", {24'd0, errCount}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("ready_after_reset", {31'd0, cmdReady}, 32'd1);

    // Legal op sweep
    applyStimulus(FUNCT_AND, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0); waitDrain();
    applyStimulus(FUNCT_OR,  32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0); waitDrain();
    applyStimulus(FUNCT_ADD, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0); waitDrain();
    applyStimulus(FUNCT_SUB, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAB, 1'b0, 1'b0); waitDrain();
    applyStimulus(FUNCT_SLT, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0); waitDrain();
    applyStimulus(FUNCT_NOR, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0); waitDrain();
    checkOutput("sweep_op_count", {16'd0, opCount}, 32'd6);

    // Swapped slt
    applyStimulus(FUNCT_SLT, 32'hAAAAAAAA, 32'h55555555, 32'h00000001, 1'b0, 1'b0); waitDrain();
    checkOutput("slt_alu_ctl", {28'd0, aluCtl}, {28'd0, CTL_SLT});
    checkOutput("slt_op_count", {16'd0, opCount}, 32'd7);

    // Illegal funct leaves the ALU inputs alone
    applyStimulus(6'b000000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1); waitDrain();
    checkOutput("illegal_err_count", {24'd0, errCount}, 32'd1);
    checkOutput("illegal_op_count", {16'd0, opCount}, 32'd7);
    checkOutput("illegal_alu_ctl", {28'd0, aluCtl}, {28'd0, CTL_SLT});
    checkOutput("illegal_alu_a", aluA, 32'hAAAAAAAA);

    // Backpressure with ignored command pulses
    rspReady = 1'b0;
    applyStimulus(FUNCT_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rspValid) seen = 1'b1;
    end
    checkOutput("bp_rsp_valid_rise", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cmdValid = (i == 1 || i == 3);
      cmdFunct = FUNCT_ADD;
      @(negedge clk);
      checkOutput("bp_rsp_valid", {31'd0, rspValid}, 32'd1);
      checkOutput("bp_rsp_data", rspData, 32'd7);
      checkOutput("bp_cmd_ready", {31'd0, cmdReady}, 32'd0);
      checkOutput("bp_op_count", {16'd0, opCount}, 32'd7);
    end
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    rspReady = 1'b1;
    waitDrain();
    checkOutput("bp_op_count_after", {16'd0, opCount}, 32'd8);
    @(negedge clk);
    checkOutput("bp_no_extra_rsp", {31'd0, rspValid}, 32'd0);
    checkOutput("bp_ready_again", {31'd0, cmdReady}, 32'd1);

    // Reset during SETTLE
    applyStimulus(FUNCT_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expQ.delete();
    checkOutput("midrst_cmd_ready", {31'd0, cmdReady}, 32'd0);
    checkOutput("midrst_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("midrst_alu_a", aluA, 32'd0);
    checkOutput("midrst_alu_b", aluB, 32'd0);
    checkOutput("midrst_alu_ctl", {28'd0, aluCtl}, 32'd0);
    checkOutput("midrst_rsp_data", rspData, 32'd0);
    checkOutput("midrst_op_count", {16'd0, opCount}, 32'd0);
    checkOutput("midrst_err_count", {24'd0, errCount}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst_cmd_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("postrst_rsp_valid", {31'd0, rspValid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("postrst_no_stale", {31'd0, rspValid}, 32'd0);

    // err_count saturation
    for (int i = 0; i < 255; i++) begin
      applyStimulus(6'b111111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      waitDrain();
    end
    checkOutput("err_count_255", {24'd0, errCount}, 32'hFF);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(6'b000001, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      waitDrain();
    end
    checkOutput("err_count_sat", {24'd0, errCount}, 32'hFF);
    checkOutput("err_phase_op_count", {16'd0, opCount}, 32'd0);

    // op_count wrap
    force dut.opCount_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.opCount_q;
    checkOutput("preload_op_count", {16'd0, opCount}, 32'hFFFF);
    applyStimulus(FUNCT_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0); waitDrain();
    checkOutput("wrap_op_count", {16'd0, opCount}, 32'd0);
    checkOutput("wrap_alu_ctl", {28'd0, aluCtl}, {28'd0, CTL_AND});

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
